// File: rtl/float_add_pipe.sv
// ---------------------------------------------------------------------------
// float_pkg + float_add_pipe
//
// Pipelined IEEE-754 single-precision adder/subtractor.
// Three register stages: align -> add -> normalize/round. The third stage
// register is the output register. A single global stall (advance) freezes
// every stage, bubbles included, whenever a valid result waits on a
// downstream that is not ready.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset, clears all stage valids/outputs
//   in_valid_i   operand pair valid
//   in_ready_o   block accepts operands this cycle (= advance)
//   a_i, b_i     operands (float_t, 32 bits)
//   sub_i        1: A-B, 0: A+B
//   out_valid_o  result valid
//   out_ready_i  downstream accepts result
//   y_o          result (float_t)
//   inexact_o    result was rounded or overflowed (qualified by out_valid_o)
//
// Build option:
//   FLOAT_ADD_SPECIALS_EN  when defined, NaN/Inf inputs follow IEEE special
//                          rules (canonical qNaN 0x7FC00000). When undefined,
//                          exponent-255 inputs are ordinary finite values.
// ---------------------------------------------------------------------------

package float_pkg;
    localparam int unsigned BiasedExponentWidth = 8;
    localparam int unsigned MantissaWidth       = 23;
    localparam int unsigned Bias                = 127;

    // Biased exponent reserved for Inf/NaN.
    localparam logic [BiasedExponentWidth-1:0] ExpAllOnes =
        BiasedExponentWidth'(2 * Bias + 1);

    typedef struct packed {
        logic                           sign;
        logic [BiasedExponentWidth-1:0] exponent;
        logic [MantissaWidth-1:0]       mantissa;
    } float_t;

    function automatic float_t neg(input float_t f);
        float_t r;
        r      = f;
        r.sign = ~f.sign;
        return r;
    endfunction

    // Significand with implicit bit; subnormals (exponent 0) have it clear.
    function automatic logic [MantissaWidth:0] float_significand(input float_t f);
        return {(f.exponent != '0), f.mantissa};
    endfunction

    // Biased exponent as used for arithmetic: subnormals behave as exponent
    // 1 (i.e. 1-Bias unbiased), so alignment against normals is seamless.
    function automatic logic [BiasedExponentWidth-1:0] float_exponent(input float_t f);
        return (f.exponent == '0) ? BiasedExponentWidth'(1) : f.exponent;
    endfunction
endpackage

module float_add_pipe
    import float_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] y_o,
    output logic        inexact_o
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic advance;
    assign advance    = !out_valid_o || out_ready_i;
    assign in_ready_o = advance;

    // ------------------------------------------------------------------
    // Stage 1: unpack, order by magnitude, align smaller operand
    // ------------------------------------------------------------------
    float_t      fa, fb, fl, fs;
    logic        swap;
    logic [7:0]  exp_l, exp_s, exp_diff;
    logic [23:0] sig_l, sig_s;
    logic [53:0] align_wide;
    logic [26:0] sig_s_aligned;
    logic        special_d;
    logic [31:0] special_val_d;

    // NOTE: every variable written here gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fa            = float_t'(a_i);
        fb            = sub_i ? neg(float_t'(b_i)) : float_t'(b_i);
        // {exponent, mantissa} ordering is monotonic in magnitude.
        swap          = fb[30:0] > fa[30:0];
        fl            = swap ? fb : fa;
        fs            = swap ? fa : fb;
        exp_l         = float_exponent(fl);
        exp_s         = float_exponent(fs);
        sig_l         = float_significand(fl);
        sig_s         = float_significand(fs);
        exp_diff      = exp_l - exp_s;
        align_wide    = '0;
        sig_s_aligned = '0;
        if (exp_diff >= 8'd27) begin
            // Everything lands below the sticky position.
            sig_s_aligned = {26'd0, |sig_s};
        end else begin
            // Upper 27 bits are the shifted field; anything falling into the
            // lower half is collapsed into the sticky bit.
            align_wide    = {sig_s, 3'b000, 27'd0} >> exp_diff;
            sig_s_aligned = {align_wide[53:28], align_wide[27] | (|align_wide[26:0])};
        end
    end

`ifdef FLOAT_ADD_SPECIALS_EN
    logic a_nan, b_nan, a_inf, b_inf;
    always_comb begin
        a_nan         = (fa.exponent == ExpAllOnes) && (fa.mantissa != '0);
        b_nan         = (fb.exponent == ExpAllOnes) && (fb.mantissa != '0);
        a_inf         = (fa.exponent == ExpAllOnes) && (fa.mantissa == '0);
        b_inf         = (fb.exponent == ExpAllOnes) && (fb.mantissa == '0);
        special_d     = a_nan || b_nan || a_inf || b_inf;
        special_val_d = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign)))
            special_val_d = QNAN;
        else if (a_inf)
            special_val_d = {fa.sign, ExpAllOnes, 23'd0};
        else if (b_inf)
            special_val_d = {fb.sign, ExpAllOnes, 23'd0};
    end
`else
    assign special_d     = 1'b0;
    assign special_val_d = '0;
`endif

    logic        s1_valid, s1_sign, s1_eff_sub, s1_special;
    logic [7:0]  s1_exp;
    logic [23:0] s1_sig_l;
    logic [26:0] s1_sig_s;
    logic [31:0] s1_special_val;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples the previous stage's pre-edge value.
    // NOTE: datapath registers are reset along with the valids; it is cheap
    // here and keeps y_o at 0 during and right after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid       <= 1'b0;
            s1_sign        <= 1'b0;
            s1_eff_sub     <= 1'b0;
            s1_special     <= 1'b0;
            s1_exp         <= '0;
            s1_sig_l       <= '0;
            s1_sig_s       <= '0;
            s1_special_val <= '0;
        end else if (advance) begin
            s1_valid       <= in_valid_i;
            s1_sign        <= fl.sign;
            s1_eff_sub     <= fl.sign ^ fs.sign;
            s1_special     <= special_d;
            s1_exp         <= exp_l;
            s1_sig_l       <= sig_l;
            s1_sig_s       <= sig_s_aligned;
            s1_special_val <= special_val_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude add/subtract (never negative: |L| >= |S|)
    // ------------------------------------------------------------------
    logic [27:0] sum_d;
    assign sum_d = s1_eff_sub ? ({1'b0, s1_sig_l, 3'b000} - {1'b0, s1_sig_s})
                              : ({1'b0, s1_sig_l, 3'b000} + {1'b0, s1_sig_s});

    logic        s2_valid, s2_sign, s2_special;
    logic [7:0]  s2_exp;
    logic [27:0] s2_sum;
    logic [31:0] s2_special_val;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid       <= 1'b0;
            s2_sign        <= 1'b0;
            s2_special     <= 1'b0;
            s2_exp         <= '0;
            s2_sum         <= '0;
            s2_special_val <= '0;
        end else if (advance) begin
            s2_valid       <= s1_valid;
            // x + (-x) is +0; a same-sign zero sum keeps the operands' sign.
            s2_sign        <= (sum_d == '0 && s1_eff_sub) ? 1'b0 : s1_sign;
            s2_special     <= s1_special;
            s2_exp         <= s1_exp;
            s2_sum         <= sum_d;
            s2_special_val <= s1_special_val;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalize, round to nearest even, pack
    // ------------------------------------------------------------------
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) n = 5'(26 - i);
        return n;
    endfunction

    logic [4:0]  lz;
    logic [7:0]  shift_lim, shift;
    logic [26:0] norm;
    logic [9:0]  exp_n, exp_f;
    logic        round_up, overflow;
    logic [32:0] rounded;
    logic [31:0] y_d;
    logic        inexact_d;

    always_comb begin
        lz        = lzc27(s2_sum[26:0]);
        shift_lim = s2_exp - 8'd1;
        shift     = '0;
        if (s2_sum[27]) begin
            // Carry-out: one right shift, dropped bit folds into sticky.
            norm  = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
            exp_n = {2'b00, s2_exp} + 10'd1;
        end else begin
            // Left-normalize, but never below biased exponent 1; what is
            // left un-normalized is a subnormal.
            shift = ({3'b000, lz} > shift_lim) ? shift_lim : {3'b000, lz};
            norm  = s2_sum[26:0] << shift;
            exp_n = {2'b00, s2_exp} - {2'b00, shift};
        end
        exp_f    = norm[26] ? exp_n : 10'd0;
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        // Mantissa carry ripples into the exponent field, which also turns a
        // rounded-up subnormal into the smallest normal.
        rounded  = {exp_f, norm[25:3]} + 33'(round_up);
        overflow = rounded[32:23] >= {2'b00, ExpAllOnes};

        y_d       = {s2_sign, rounded[30:0]};
        inexact_d = |norm[2:0];
        if (s2_special) begin
            y_d       = s2_special_val;
            inexact_d = 1'b0;
        end else if (s2_sum == '0) begin
            y_d       = {s2_sign, 31'd0};
            inexact_d = 1'b0;
        end else if (overflow) begin
            y_d       = {s2_sign, ExpAllOnes, 23'd0};
            inexact_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            y_o         <= '0;
            inexact_o   <= 1'b0;
        end else if (advance) begin
            out_valid_o <= s2_valid;
            if (s2_valid) begin
                y_o       <= y_d;
                inexact_o <= inexact_d;
            end
        end
    end

endmodule
